// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage in-order core. Tracks a shadow
//   copy of the EX/MEM/WB register-destination fields so that it can
//   generate operand forwarding selects, detect load-use hazards, insert
//   bubbles on control redirects, and freeze the whole pipe while a data
//   memory access is outstanding (with a timeout into a sticky error state).
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   id_rs1, id_rs2        source registers of the instruction in ID
//   id_use_rs1/_rs2       ID instruction actually reads rs1 / rs2
//   id_rd                 destination register of the ID instruction
//   id_wb                 {reg_write, mem_to_reg[1:0]}; mem_to_reg==2'b11 is a load
//   ex_redirect           taken branch / jump resolved in EX this cycle
//   mem_req, mem_ready    data access pending in MEM / access completes now
//   front_stall           hold PC and IF/ID
//   back_stall            hold ID/EX, EX/MEM, MEM/WB
//   ifid_flush/idex_flush bubble into IF/ID / ID/EX on next edge
//   fwd_a, fwd_b          EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   mem_timeout           sticky memory-timeout error flag
//   stall_cnt, flush_cnt  saturating performance counters
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic [2:0]  id_wb,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        front_stall,
    output logic        back_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    // EX-stage shadow (_p0)
    logic [4:0] rs1_p0;
    logic [4:0] rs2_p0;
    logic [4:0] rd_p0;
    logic       wr_p0;
    logic       load_p0;
    // MEM-stage shadow (_p1)
    logic [4:0] rd_p1;
    logic       wr_p1;
    // WB-stage shadow (_p2)
    logic [4:0] rd_p2;
    logic       wr_p2;

    logic frozen;
    logic load_use;
    logic redirect;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The nearer (younger) producer wins, so EX/MEM is checked before MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_mem,
        input logic [4:0] rd_mem,
        input logic       wr_wb,
        input logic [4:0] rd_wb
    );
        if (wr_mem && (rd_mem != 5'd0) && (rd_mem == rs))
            return 2'b01;
        else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // wait_cnt holds the number of MEM_WAIT cycles already completed; the
    // timeout decision looks at the incremented value so that the error is
    // taken at the end of the MEM_TIMEOUT-th waiting cycle, and a mem_ready
    // arriving in that same cycle still returns to RUN.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_nxt == TIMEOUT_V)
                        state_nxt = ERROR;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // While frozen nothing in the pipe moves, so redirects and load-use
    // bubbles are simply held back until the memory access completes.
    always_comb begin
        frozen   = (state == ERROR) || (mem_req && !mem_ready);
        load_use = load_p0 && wr_p0 && (rd_p0 != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == rd_p0)) ||
                    (id_use_rs2 && (id_rs2 == rd_p0)));
        redirect = !frozen && ex_redirect;

        front_stall = frozen || (load_use && !redirect);
        back_stall  = frozen;
        ifid_flush  = redirect;
        idex_flush  = !frozen && (redirect || load_use);
        mem_timeout = (state == ERROR);

        fwd_a = fwd_sel(rs1_p0, wr_p1, rd_p1, wr_p2, rd_p2);
        fwd_b = fwd_sel(rs2_p0, wr_p1, rd_p1, wr_p2, rd_p2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (front_stall)
                stall_cnt <= sat_inc(stall_cnt);
            if (ifid_flush || idex_flush)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    // ID -> EX shadow boundary (control bits)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_p0   <= 1'b0;
            load_p0 <= 1'b0;
            wr_p1   <= 1'b0;
            wr_p2   <= 1'b0;
        end else if (!back_stall) begin
            wr_p0   <= id_wb[2] && !idex_flush;
            load_p0 <= (id_wb[1:0] == 2'b11) && !idex_flush;
            wr_p1   <= wr_p0;
            wr_p2   <= wr_p1;
        end
    end

    // ID -> EX -> MEM -> WB shadow boundary (register numbers)
    always_ff @(posedge clk) begin
        if (!back_stall) begin
            rs1_p0 <= id_rs1;
            rs2_p0 <= id_rs2;
            rd_p0  <= id_rd;
            rd_p1  <= rd_p0;
            rd_p2  <= rd_p1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. A behavioural model keeps the
//   in-flight instructions as a queue (index 0 = EX, 1 = MEM, 2 = WB) and
//   derives every expected output from the hazard rules each cycle, alongside
//   directed scenarios with fixed expected values.
module tb_hazard_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [2:0]  id_wb;
    logic        ex_redirect, mem_req, mem_ready;
    logic        front_stall, back_stall, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wb(id_wb),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .front_stall(front_stall), .back_stall(back_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } ins_t;

    ins_t pipe[$];
    int   m_mode;      // 0 running, 1 waiting on memory, 2 error
    int   m_waited;    // waiting cycles spent in the current memory wait
    int   m_sc, m_fc;
    bit   e_front, e_back, e_ifid, e_idex;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ins_t b;
        b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.wr = 0; b.load = 0;
        pipe = {b, b, b};
        m_mode = 0; m_waited = 0; m_sc = 0; m_fc = 0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        for (int k = 1; k <= 2; k++)
            if (pipe[k].wr && pipe[k].rd != 0 && pipe[k].rd == rs)
                return 2'(k);
        return 2'b00;
    endfunction

    // Settle combinational outputs, then compare everything against the model.
    task automatic look();
        bit frz, lu, redir;
        #1;
        frz   = (m_mode == 2) || (mem_req && !mem_ready);
        lu    = pipe[0].load && pipe[0].wr && pipe[0].rd != 0 &&
                ((id_use_rs1 && id_rs1 == pipe[0].rd) || (id_use_rs2 && id_rs2 == pipe[0].rd));
        redir = !frz && ex_redirect;
        e_front = frz || (lu && !redir);
        e_back  = frz;
        e_ifid  = redir;
        e_idex  = !frz && (redir || lu);
        chk("front_stall", 16'(front_stall), 16'(e_front));
        chk("back_stall",  16'(back_stall),  16'(e_back));
        chk("ifid_flush",  16'(ifid_flush),  16'(e_ifid));
        chk("idex_flush",  16'(idex_flush),  16'(e_idex));
        chk("fwd_a",       16'(fwd_a),       16'(exp_fwd(pipe[0].rs1)));
        chk("fwd_b",       16'(fwd_b),       16'(exp_fwd(pipe[0].rs2)));
        chk("mem_timeout", 16'(mem_timeout), 16'(m_mode == 2));
        chk("stall_cnt",   stall_cnt,        16'(m_sc));
        chk("flush_cnt",   flush_cnt,        16'(m_fc));
    endtask

    task automatic tick();
        ins_t n;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_front && m_sc < 65535) m_sc++;
            if ((e_ifid || e_idex) && m_fc < 65535) m_fc++;
            if (!e_back) begin
                n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
                n.wr   = id_wb[2] && !e_idex;
                n.load = (id_wb[1:0] == 2'b11) && !e_idex;
                pipe.push_front(n);
                void'(pipe.pop_back());
            end
            if (m_mode == 0) begin
                if (mem_req && !mem_ready) begin
                    m_mode = 1; m_waited = 0;
                end
            end else if (m_mode == 1) begin
                m_waited++;
                if (mem_ready) begin
                    m_mode = 0; m_waited = 0;
                end else if (m_waited == TMO) begin
                    m_mode = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        look();
        tick();
    endtask

    task automatic set_id(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic [2:0] wb);
        id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2; id_rd = rd; id_wb = wb;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic do_reset();
        rst = 1; nop(); ex_redirect = 0; mem_req = 0; mem_ready = 0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 1; nop(); ex_redirect = 0; mem_req = 0; mem_ready = 0;
        @(negedge clk);
        do_reset();

        // reset state
        look();
        chk("rst_front", 16'(front_stall), 16'd0);
        chk("rst_back",  16'(back_stall),  16'd0);
        chk("rst_flush", 16'({ifid_flush, idex_flush}), 16'd0);
        chk("rst_fwd",   16'({fwd_a, fwd_b}), 16'd0);
        chk("rst_tmo",   16'(mem_timeout), 16'd0);
        chk("rst_cnts",  stall_cnt | flush_cnt, 16'd0);
        tick();

        // load x5 ; add x6,x5,x7
        set_id(1, 1, 0, 0, 5, 3'b111);
        cycle();
        set_id(5, 1, 7, 1, 6, 3'b100);
        look();
        chk("lu_front", 16'(front_stall), 16'd1);
        chk("lu_idex",  16'(idex_flush),  16'd1);
        chk("lu_ifid",  16'(ifid_flush),  16'd0);
        tick();
        look();
        chk("lu_once", 16'(front_stall), 16'd0);
        tick();
        nop();
        look();
        chk("lu_fwd_a", 16'(fwd_a), 16'b10);
        chk("lu_fwd_b", 16'(fwd_b), 16'b00);
        chk("lu_stall_cnt", stall_cnt, 16'd1);
        tick();

        // add x5 ; sub x8,x5,x5 back to back
        do_reset();
        set_id(1, 1, 2, 1, 5, 3'b100);
        cycle();
        set_id(5, 1, 5, 1, 8, 3'b100);
        look();
        chk("b2b_nostall", 16'(front_stall), 16'd0);
        tick();
        nop();
        look();
        chk("b2b_fwd_a", 16'(fwd_a), 16'b01);
        chk("b2b_fwd_b", 16'(fwd_b), 16'b01);
        tick();

        // writer to x0 never forwards
        do_reset();
        set_id(1, 1, 2, 1, 0, 3'b100);
        cycle();
        set_id(0, 1, 0, 1, 8, 3'b100);
        cycle();
        nop();
        look();
        chk("x0_fwd", 16'({fwd_a, fwd_b}), 16'd0);
        tick();

        // redirect together with load-use
        do_reset();
        set_id(1, 1, 0, 0, 5, 3'b111);
        cycle();
        set_id(5, 1, 7, 1, 6, 3'b100);
        ex_redirect = 1;
        look();
        chk("rd_ifid",  16'(ifid_flush),  16'd1);
        chk("rd_idex",  16'(idex_flush),  16'd1);
        chk("rd_front", 16'(front_stall), 16'd0);
        tick();
        ex_redirect = 0; nop();
        look();
        chk("rd_flush_cnt", flush_cnt, 16'd1);
        tick();

        // memory wait of three cycles, forwarding held
        do_reset();
        set_id(1, 1, 2, 1, 5, 3'b100);
        cycle();
        set_id(5, 1, 5, 1, 8, 3'b100);
        cycle();
        nop();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("mw_front", 16'(front_stall), 16'd1);
            chk("mw_back",  16'(back_stall),  16'd1);
            chk("mw_fwd",   16'({fwd_a, fwd_b}), 16'b0101);
            tick();
        end
        mem_ready = 1;
        look();
        chk("mw_release", 16'(front_stall), 16'd0);
        tick();
        mem_req = 0; mem_ready = 0;
        look();
        chk("mw_stall_cnt", stall_cnt, 16'd3);
        chk("mw_no_tmo",    16'(mem_timeout), 16'd0);
        tick();

        // mem_ready on the last allowed waiting cycle wins
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (TMO) cycle();
        mem_ready = 1;
        cycle();
        mem_req = 0; mem_ready = 0;
        look();
        chk("win_tmo",   16'(mem_timeout), 16'd0);
        chk("win_front", 16'(front_stall), 16'd0);
        tick();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_id(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            mem_req     = ($urandom_range(0, 4) == 0);
            mem_ready   = ($urandom_range(0, 9) < 6);
            ex_redirect = (m_mode == 0) && ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0; ex_redirect = 0; nop();

        // timeout into sticky error
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (TMO + 1) cycle();
        mem_req = 0;
        look();
        chk("err_tmo",   16'(mem_timeout), 16'd1);
        chk("err_front", 16'(front_stall), 16'd1);
        chk("err_back",  16'(back_stall),  16'd1);
        tick();
        mem_ready = 1;
        repeat (5) cycle();
        look();
        chk("err_sticky", 16'(mem_timeout), 16'd1);
        tick();

        // stall counter saturation while held in error
        repeat (65540) cycle();
        look();
        chk("sat_stall", stall_cnt, 16'hFFFF);
        tick();
        repeat (300) cycle();
        look();
        chk("sat_hold", stall_cnt, 16'hFFFF);
        tick();

        // reset out of error with mem_req still high
        rst = 1; mem_req = 1; mem_ready = 0;
        cycle();
        rst = 0; mem_req = 0;
        look();
        chk("rec_tmo",   16'(mem_timeout), 16'd0);
        chk("rec_front", 16'(front_stall), 16'd0);
        chk("rec_cnts",  stall_cnt | flush_cnt, 16'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
